fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the address of the first fetch after reset.
REQ-002 SHALL have port clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning reset, asynchronous and active-high.
REQ-004 SHALL have port imem_req  output  1  meaning an instruction-memory read request is pending.
REQ-005 SHALL have port imem_addr  output  32  meaning the byte address of the pending request.
REQ-006 SHALL have port imem_ack  input  1  meaning imem_rdata is valid this cycle; may be asserted in the same cycle as imem_req.
REQ-007 SHALL have port imem_rdata  input  32  meaning the instruction word.
REQ-008 SHALL have port redirect_valid  input  1  meaning the downstream stage requests a PC change (taken branch) this cycle.
REQ-009 SHALL have port redirect_pc  input  32  meaning the redirect target.
REQ-010 SHALL have port if_valid  output  1  meaning if_instr, if_pc and if_pc4 hold a fetched instruction.
REQ-011 SHALL have port if_ready  input  1  meaning the downstream stage accepts the instruction this cycle.
REQ-012 SHALL have ports if_instr, if_pc and if_pc4  output  32 each  meaning the instruction, its address, and its address plus 4.
REQ-013 SHALL have port fetch_count  output  32  meaning the number of accepted instructions (if_valid && if_ready && !redirect_valid).
REQ-014 SHALL have port misalign_err  output  1  meaning a misaligned redirect was detected (see Configuration).

Function
REQ-015 SHALL implement the FSM states IDLE, FETCH, DRAIN and HOLD, plus HALT under FETCH_ALIGN_CHECK_EN.
REQ-016 IDLE: imem_req=0; unconditional transition to FETCH on the next edge.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_ack without redirect, latch if_instr=imem_rdata, if_pc=pc, if_pc4=pc+4, set if_valid=1, set pc<=pc+4, and move to HOLD.
REQ-018 FETCH on imem_ack with redirect_valid in the same cycle: data discarded, pc<=redirect_pc, remain in FETCH.
REQ-019 FETCH on redirect_valid without imem_ack: pc<=redirect_pc and move to DRAIN.
REQ-020 Handshake rule: imem_addr stays stable while imem_req=1 until imem_ack, so DRAIN drives imem_req=1 with the old address and returns to FETCH on imem_ack, discarding the data.
REQ-021 DRAIN on a second redirect: the latest redirect_pc wins.
REQ-022 HOLD: outputs stable; on if_ready, clear if_valid, increment fetch_count and move to FETCH.
REQ-023 Redirect has priority over if_ready in HOLD: the held instruction is dropped, fetch_count does not increment, if_valid=0 next cycle, pc<=redirect_pc, and the FSM moves to FETCH.
REQ-024 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000; fetch_count also wraps.
REQ-025 Zero-wait memory (ack in the same cycle as req) SHALL give one instruction every 2 cycles when if_ready=1 continuously.

Reset
REQ-026 Assertion of reset SHALL immediately force: state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc4=0, fetch_count=0, misalign_err=0, imem_req=0.
REQ-027 Reset during FETCH/DRAIN SHALL abandon the outstanding request; an imem_ack arriving while in IDLE is ignored.

Configuration
REQ-028 Macro FETCH_ALIGN_CHECK_EN defined: redirect_valid with redirect_pc[1:0]!=0 enters HALT, setting sticky misalign_err=1 with imem_req=0 and if_valid=0 until reset.
REQ-029 Macro FETCH_ALIGN_CHECK_EN undefined: redirect_pc[1:0] is treated as 2'b00, misalign_err is tied to 0, and HALT does not exist.

Structure
REQ-030 Package fetch_pkg SHALL hold the FSM state enum, the PC_INCR=4 constant and the default RESET_PC.
REQ-031 One sub-module fetch_pc_reg (PC register with async reset, increment/redirect select) is natural; the FSM and output registers stay in fetch_unit.

Verification
REQ-032 Reset release, zero-wait memory, if_ready=1: imem_addr sequence 0,4,8; if_pc 0,4,8 every 2 cycles; fetch_count=3 after the third accept.
REQ-033 Memory with 3-cycle ack latency, redirect to 0x40 in the second wait cycle: DRAIN holds imem_addr=0 until ack; next request is to 0x40; the first if_pc is 0x40.
REQ-034 HOLD with if_ready=0 for 5 cycles, then if_ready=1 and redirect_valid=1 (target 0x100) in the same cycle: fetch_count unchanged; next if_pc=0x100.
REQ-035 RESET_PC=32'hFFFF_FFFC: first if_pc=FFFF_FFFC with if_pc4=0, second if_pc=0.
REQ-036 With FETCH_ALIGN_CHECK_EN, redirect to 0x102: misalign_err=1 next cycle, imem_req stays 0, and reset clears both.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and PC constants for the fetch unit.
// HALT exists only when FETCH_ALIGN_CHECK_EN is defined.
package fetch_pkg;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        HOLD  = 3'd3,
        HALT  = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        HOLD  = 3'd3
    } state_e;
`endif
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with async reset; redirect takes priority over increment.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_incr,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc
);
    logic [31:0] r_pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_pc <= RESET_PC;
        else if (i_redirect) r_pc <= i_target;
        else if (i_incr) r_pc <= r_pc + PC_INCR;
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request instruction fetch with redirect and drain handling.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);
    state_e      r_state, w_next;
    logic [31:0] w_pc, w_target, r_drain_addr;
    logic        w_active, w_misalign, w_redir, w_capture, w_accept;
    logic        r_if_valid;
    logic [31:0] r_if_instr, r_if_pc, r_if_pc4, r_fetch_count;

    assign w_active = r_state == FETCH || r_state == DRAIN || r_state == HOLD;
`ifdef FETCH_ALIGN_CHECK_EN
    assign w_target   = redirect_pc;
    assign w_misalign = w_active && redirect_valid && |redirect_pc[1:0];
`else
    assign w_target   = redirect_pc & ~32'h3;
    assign w_misalign = 1'b0;
`endif
    assign w_redir   = w_active && redirect_valid && !w_misalign;
    assign w_capture = r_state == FETCH && imem_ack && !redirect_valid;
    assign w_accept  = r_state == HOLD && if_ready && !redirect_valid;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clock      (clock),
        .reset      (reset),
        .i_incr     (w_capture),
        .i_redirect (w_redir),
        .i_target   (w_target),
        .o_pc       (w_pc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = FETCH;
            FETCH:   w_next = imem_ack ? (redirect_valid ? FETCH : HOLD) : (redirect_valid ? DRAIN : FETCH);
            DRAIN:   w_next = imem_ack ? FETCH : DRAIN;
            HOLD:    w_next = (redirect_valid || if_ready) ? FETCH : HOLD;
            default: w_next = r_state;
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        if (w_misalign) w_next = HALT;
`endif
    end

    // r_drain_addr remembers the address of the abandoned request so DRAIN keeps it stable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_drain_addr  <= '0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_pc4      <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == FETCH) r_drain_addr <= w_pc;
            if (w_capture) begin
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rdata;
                r_if_pc    <= w_pc;
                r_if_pc4   <= w_pc + PC_INCR;
            end else if (r_state == HOLD && (redirect_valid || if_ready)) begin
                r_if_valid <= 1'b0;
            end
            if (w_accept) r_fetch_count <= r_fetch_count + 32'd1;
            if (w_misalign) r_if_valid <= 1'b0;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign_err;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_misalign_err <= 1'b0;
        else if (w_misalign) r_misalign_err <= 1'b1;
    end
    assign misalign_err = r_misalign_err;
`else
    assign misalign_err = 1'b0;
`endif

    assign imem_req    = r_state == FETCH || r_state == DRAIN;
    assign imem_addr   = r_state == DRAIN ? r_drain_addr : w_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc4      = r_if_pc4;
    assign fetch_count = r_fetch_count;
endmodule
